// File: rtl/memory_requester.sv
// Cache-miss initiator toward main memory: optional dirty-line write-back,
// then the line fill read, with start gating on mem_in_use and a per-transaction timeout.
module memory_requester #(
    parameter int MEMORY_ADDRESS_SIZE = 32,
    parameter int CACHE_LINE_SIZE     = 128,
    parameter int TIMEOUT_CYCLES      = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_writeback,
    input  logic [MEMORY_ADDRESS_SIZE-1:0] req_wb_address,
    input  logic [CACHE_LINE_SIZE-1:0]     req_wb_line,
    input  logic [MEMORY_ADDRESS_SIZE-1:0] req_fill_address,
    output logic                           resp_valid,
    output logic [CACHE_LINE_SIZE-1:0]     resp_line,
    output logic                           resp_error,
    output logic                           mem_enable,
    output logic                           mem_op,
    output logic [MEMORY_ADDRESS_SIZE-1:0] mem_address,
    output logic [CACHE_LINE_SIZE-1:0]     mem_data_in,
    input  logic [CACHE_LINE_SIZE-1:0]     mem_data_out,
    input  logic                           mem_data_ready,
    input  logic                           mem_in_use
);

    localparam int OFFSET_BITS = $clog2(CACHE_LINE_SIZE / 8);
    localparam int CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [MEMORY_ADDRESS_SIZE-1:0] ALIGN_MASK =
        {{(MEMORY_ADDRESS_SIZE - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_GAP,
        FILL_REQ,
        RESP
    } state_t;

    state_t                         state, state_next;
    logic                           enable_next;
    logic                           capture;
    logic                           fill_done;
    logic                           timed_out;
    logic                           timeout_hit;
    logic [CNT_W-1:0]               timeout_count;
    logic [MEMORY_ADDRESS_SIZE-1:0] wb_address;
    logic [MEMORY_ADDRESS_SIZE-1:0] fill_address;
    logic [CACHE_LINE_SIZE-1:0]     wb_line;

    // Last enabled cycle without data_ready: dropping here keeps enable high exactly TIMEOUT_CYCLES.
    assign timeout_hit = mem_enable && !mem_data_ready &&
                         (timeout_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next  = state;
        enable_next = 1'b0;
        capture     = 1'b0;
        fill_done   = 1'b0;
        timed_out   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    capture     = 1'b1;
                    state_next  = req_writeback ? WB_REQ : FILL_REQ;
                    enable_next = !mem_in_use;
                end
            end
            WB_REQ: begin
                if (!mem_enable) begin
                    enable_next = !mem_in_use;
                end else if (mem_data_ready) begin
                    state_next = WB_GAP;
                end else if (timeout_hit) begin
                    state_next = RESP;
                    timed_out  = 1'b1;
                end else begin
                    enable_next = 1'b1;
                end
            end
            WB_GAP: begin
                state_next  = FILL_REQ;
                enable_next = !mem_in_use;
            end
            FILL_REQ: begin
                if (!mem_enable) begin
                    enable_next = !mem_in_use;
                end else if (mem_data_ready) begin
                    state_next = RESP;
                    fill_done  = 1'b1;
                end else if (timeout_hit) begin
                    state_next = RESP;
                    timed_out  = 1'b1;
                end else begin
                    enable_next = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mem_enable    <= 1'b0;
            timeout_count <= '0;
            wb_address    <= '0;
            fill_address  <= '0;
            wb_line       <= '0;
            resp_line     <= '0;
            resp_error    <= 1'b0;
        end else begin
            state      <= state_next;
            mem_enable <= enable_next;

            if (state_next != state) begin
                timeout_count <= '0;
            end else if (mem_enable) begin
                timeout_count <= timeout_count + CNT_W'(1);
            end

            if (capture) begin
                wb_address   <= req_wb_address;
                fill_address <= req_fill_address;
                wb_line      <= req_wb_line;
                resp_error   <= 1'b0;
            end

            if (fill_done) begin
                resp_line  <= mem_data_out;
                resp_error <= 1'b0;
            end else if (timed_out) begin
                resp_line  <= '0;
                resp_error <= 1'b1;
            end
        end
    end

    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign mem_op      = (state == WB_REQ);
    assign mem_address = ((state == WB_REQ) ? wb_address : fill_address) & ALIGN_MASK;
    assign mem_data_in = wb_line;

endmodule

// File: doc/memory_requester.md
# memory_requester

Initiator side of the main-memory line interface. Accepts one cache-miss request at a time from the data/instruction cache. For a dirty victim it first issues a line write-back, then issues the line fill read, and returns the filled 128-bit line to the cache. It drives the same enable/op/address/data_in handshake that the memory module responds to, and holds enable until the memory reports data_ready.

## Interface
- MEMORY_ADDRESS_SIZE, 32: byte address width toward memory.
- CACHE_LINE_SIZE, 128: line width in bits.
- TIMEOUT_CYCLES, 64: maximum cycles a single memory transaction may stay outstanding.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  cache presents a miss request.
- req_ready  output  1  block can accept a request (IDLE only).
- req_writeback  input  1  victim line is dirty; write it back before the fill.
- req_wb_address  input  MEMORY_ADDRESS_SIZE  victim line address.
- req_wb_line  input  CACHE_LINE_SIZE  victim line data.
- req_fill_address  input  MEMORY_ADDRESS_SIZE  missing line address.
- resp_valid  output  1  one-cycle pulse: fill complete or aborted.
- resp_line  output  CACHE_LINE_SIZE  filled line; valid with resp_valid.
- resp_error  output  1  qualifies resp_valid: transaction timed out.
- mem_enable  output  1  memory request, held until completion.
- mem_op  output  1  1 = write, 0 = read.
- mem_address  output  MEMORY_ADDRESS_SIZE  line-aligned address.
- mem_data_in  output  CACHE_LINE_SIZE  write data.
- mem_data_out  input  CACHE_LINE_SIZE  read data from memory.
- mem_data_ready  input  1  memory completed the current transaction.
- mem_in_use  input  1  memory busy with another master; no new enable may start.

## Operation
- States: IDLE, WB_REQ, WB_GAP, FILL_REQ, RESP.
- IDLE: req_ready=1. On req_valid, capture all req_* fields into internal registers, then go to WB_REQ if req_writeback, else FILL_REQ.
- WB_REQ: mem_enable=1, mem_op=1, mem_address=captured wb address, mem_data_in=captured line. On mem_data_ready, go to WB_GAP.
- WB_GAP: mem_enable=0 for exactly one cycle, then go to FILL_REQ.
- FILL_REQ: mem_enable=1, mem_op=0, mem_address=captured fill address. On mem_data_ready, register mem_data_out into resp_line and go to RESP.
- RESP: resp_valid=1 for one cycle, mem_enable=0, then go to IDLE.
- Start gating: WB_REQ/FILL_REQ do not raise mem_enable while mem_enable is currently 0 and mem_in_use=1. They stall with mem_enable=0. Once mem_enable is raised, mem_in_use is ignored until completion.
- Addresses are line-aligned. The low log2(CACHE_LINE_SIZE/8) bits of mem_address are forced to 0.
- mem_op, mem_address and mem_data_in are stable for the entire time mem_enable=1.
- Timeout: a counter clears on entry to each REQ state and increments every cycle mem_enable=1. If it reaches TIMEOUT_CYCLES with no mem_data_ready, the block:
  - drops mem_enable,
  - skips any remaining fill,
  - enters RESP with resp_error=1 and resp_line=0.
- mem_data_ready is only honoured while mem_enable=1. It is ignored in IDLE, WB_GAP and RESP.
- A req_valid arriving while not in IDLE is not accepted. The cache holds it.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_line=0, mem_enable=0, mem_op=0, mem_address=0, mem_data_in=0, timeout counter 0.
- Reset in any state, including mid-transaction, drops mem_enable the next edge and discards the captured request. No resp_valid is produced.
- Accept at edge T. mem_enable=1 is visible from cycle T+1, unless stalled by mem_in_use.
- Completion: mem_data_ready sampled high at edge N means mem_enable=0 from cycle N+1.
- Fill-only latency: resp_valid in cycle N+1, where N is the fill completion edge. req_ready returns in cycle N+2.
- Write-back then fill: the read enable rises 2 cycles after write completion (one WB_GAP cycle), subject to mem_in_use.
- Every pair of transactions is separated by at least one cycle with mem_enable=0.

## Test plan
- Fill only, memory delay 5 cycles, fill address 0x0000_0010, memory holds 0x00FF…00FF → one read with mem_op=0 and address 0x10; resp_valid pulses once with resp_line=0x00FF00FF00FF00FF00FF00FF00FF00FF; resp_error=0.
- Write-back line 0xDEAD…BEEF to 0x20, then fill from 0x30 → write then read; exactly one mem_enable=0 cycle between them; reading 0x20 afterwards returns 0xDEAD…BEEF.
- mem_in_use=1 for 4 cycles at request time → mem_enable stays 0 for those cycles and rises the cycle after mem_in_use falls; response data is correct.
- Unaligned fill address 0x0000_0017 → mem_address=0x0000_0010.
- Memory never asserts data_ready, TIMEOUT_CYCLES=8 → mem_enable is high for 8 cycles then drops; resp_valid=1 with resp_error=1 and resp_line=0; req_ready returns.
- reset asserted 2 cycles into a FILL_REQ → next cycle mem_enable=0 and state is IDLE; no resp_valid; a following request completes normally.
